// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mult_div_unit
//  Purpose  : Iterative multiply/divide unit feeding the HI/LO special
//             registers. MULT/MULTU use shift-add, DIV/DIVU use restoring
//             division on operand magnitudes, one iteration per clock, with
//             sign fix-up applied when the result is written.
//  Ports    : CLK          clock, rising edge
//             Reset        asynchronous active-low reset
//             Start        launch request, sampled only when idle
//             Op[1:0]      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//             SrcA, SrcB   rs / rt data (multiplicand/dividend, multiplier/divisor)
//             HiWre, LoWre MTHI / MTLO write enables (write SrcA when idle)
//             Busy, Done   handshake to control (Done is a one-cycle pulse)
//             HI, LO       special registers
//  Revision : 1.0  initial release
// ============================================================================
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             HiWre,
    input  logic             LoWre,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = $clog2(ITER) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic                 r_is_div;
    logic                 r_dz;       // divide by zero: skip iterations
    logic                 r_neg_lo;   // negate product / quotient
    logic                 r_neg_hi;   // negate remainder
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_acc;      // {partial hi / remainder, multiplier / dividend}
    logic [WIDTH-1:0]     r_opb;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic                 w_dz;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic                 w_fin_now;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_nxt;
    logic [WIDTH:0]       w_rem_sh;
    logic                 w_rem_ge;
    logic [WIDTH-1:0]     w_rem_sub;
    logic [2*WIDTH-1:0]   w_div_nxt;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;

    assign w_dz    = Op[1] && (SrcB == '0);
    assign w_mag_a = (Op[0] && SrcA[WIDTH-1]) ? -SrcA : SrcA;
    assign w_mag_b = (Op[0] && SrcB[WIDTH-1]) ? -SrcB : SrcB;

    // Divide-by-zero still spends one RUN cycle so the result lands at E1.
    assign w_fin_now = (r_state == S_RUN) && (r_dz || (r_cnt == CW'(ITER)));

    // Shift-add step: conditionally add multiplicand to the upper half, then
    // shift the whole accumulator right with the carry entering at the top.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring step: shift the next dividend bit into the remainder and
    // subtract when it fits. The difference is below the divisor, so the
    // modulo-2^WIDTH subtraction is exact.
    assign w_rem_sh  = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_rem_ge  = (w_rem_sh >= {1'b0, r_opb});
    assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_opb;
    assign w_div_nxt = {(w_rem_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0]),
                        r_acc[WIDTH-2:0], w_rem_ge};

    assign w_prod = r_neg_lo ? -r_acc : r_acc;
    assign w_quo  = r_neg_lo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_hi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        Busy        = 1'b0;
        Done        = 1'b0;
        case (r_state)
            S_IDLE: if (Start) w_state_nxt = S_RUN;
            S_RUN: begin
                Busy = 1'b1;
                if (w_fin_now) w_state_nxt = S_FIN;
            end
            S_FIN: begin
                Busy        = 1'b1;
                Done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_is_div <= 1'b0;
            r_dz     <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        // Start takes priority; any MTHI/MTLO this cycle is dropped.
                        r_is_div <= Op[1];
                        r_dz     <= w_dz;
                        r_neg_lo <= Op[0] & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
                        r_neg_hi <= Op[0] & SrcA[WIDTH-1];
                        r_cnt    <= '0;
                        if (w_dz) begin
                            r_acc <= {{WIDTH{1'b0}}, SrcA};   // raw dividend returned in HI
                            r_opb <= '0;
                        end else if (Op[1]) begin
                            r_acc <= {{WIDTH{1'b0}}, w_mag_a};
                            r_opb <= w_mag_b;
                        end else begin
                            r_acc <= {{WIDTH{1'b0}}, w_mag_b};
                            r_opb <= w_mag_a;
                        end
                    end else begin
                        if (HiWre) r_hi <= SrcA;
                        if (LoWre) r_lo <= SrcA;
                    end
                end
                S_RUN: begin
                    if (w_fin_now) begin
                        if (r_dz) begin
                            r_hi <= r_acc[WIDTH-1:0];
                            r_lo <= '1;
                        end else if (r_is_div) begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end else begin
                            {r_hi, r_lo} <= w_prod;
                        end
                    end else begin
                        r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign HI = r_hi;
    assign LO = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_div_unit
//  Purpose  : Self-checking bench for mult_div_unit using an arithmetic
//             reference model of MULT/MULTU/DIV/DIVU and HI/LO behaviour.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mult_div_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        HiWre;
    logic        LoWre;
    logic        Busy;
    logic        Done;
    logic [31:0] HI;
    logic [31:0] LO;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .Start (Start),
        .Op    (Op),
        .SrcA  (SrcA),
        .SrcB  (SrcB),
        .HiWre (HiWre),
        .LoWre (LoWre),
        .Busy  (Busy),
        .Done  (Done),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 CLK = ~CLK;

    // Reference result {HI, LO} from plain arithmetic.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] ea, eb;
        int sa, sb;
        case (op)
            2'b00: return {32'b0, a} * {32'b0, b};
            2'b01: begin
                ea = {{32{a[31]}}, a};
                eb = {{32{b[31]}}, b};
                return ea * eb;
            end
            2'b10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                sa = $signed(a);
                sb = $signed(b);
                return {32'(sa % sb), 32'(sa / sb)};
            end
        endcase
    endfunction

    // Launch one operation and follow it to completion.
    task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit with_hiwre, input bit disturb);
        logic [63:0] r;
        int lat, exp_lat;
        bit seen, busy_ok, hold_ok;
        r       = model(op, a, b);
        exp_lat = (op[1] && b == 0) ? 1 : 33;
        @(negedge CLK);
        Start = 1'b1; Op = op; SrcA = a; SrcB = b; HiWre = with_hiwre; LoWre = 1'b0;
        @(negedge CLK);   // E0 has passed
        Start = 1'b0; HiWre = 1'b0;
        SrcA = $urandom; SrcB = $urandom; Op = 2'($urandom);
        checks++;
        if (Busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start: got %b want 1", name, Busy);
        end
        seen = 0; lat = 0; busy_ok = 1; hold_ok = 1;
        for (int k = 1; k <= 40 && !seen; k++) begin
            if (disturb && k == 10) begin
                Start = 1'b1; Op = 2'b10; HiWre = 1'b1; SrcA = 32'h0000_DEAD;
            end
            if (disturb && k == 11) begin
                Start = 1'b0; HiWre = 1'b0;
            end
            @(negedge CLK);   // edge E_k has passed
            if (Done === 1'b1) begin
                seen = 1; lat = k;
            end else begin
                if (Busy !== 1'b1) busy_ok = 0;
                if (k == 5 && (HI !== exp_hi || LO !== exp_lo)) hold_ok = 0;
            end
        end
        Start = 1'b0; HiWre = 1'b0;
        checks++;
        if (!seen || lat != exp_lat) begin
            errors++;
            $display("FAIL %s done_latency: got %0d want %0d", name, lat, exp_lat);
        end
        checks++;
        if (!busy_ok) begin
            errors++;
            $display("FAIL %s busy_during_run: got 0 want 1", name);
        end
        if (exp_lat > 5) begin
            checks++;
            if (!hold_ok) begin
                errors++;
                $display("FAIL %s hilo_hold_during_run: want %h_%h", name, exp_hi, exp_lo);
            end
        end
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        checks++;
        if (HI !== exp_hi || LO !== exp_lo) begin
            errors++;
            $display("FAIL %s result: got HI=%h LO=%h want HI=%h LO=%h", name, HI, LO, exp_hi, exp_lo);
        end
        @(negedge CLK);
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after_done: got Busy=%b Done=%b want 0 0", name, Busy, Done);
        end
    endtask

    task automatic mt_write(input bit hw, input bit lw, input logic [31:0] a);
        @(negedge CLK);
        HiWre = hw; LoWre = lw; SrcA = a; Start = 1'b0;
        @(negedge CLK);
        HiWre = 1'b0; LoWre = 1'b0; SrcA = $urandom;
        if (hw) exp_hi = a;
        if (lw) exp_lo = a;
        checks++;
        if (HI !== exp_hi || LO !== exp_lo) begin
            errors++;
            $display("FAIL mt_write: got HI=%h LO=%h want HI=%h LO=%h", HI, LO, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0; Start = 1'b0; Op = 2'b00; SrcA = '0; SrcB = '0; HiWre = 1'b0; LoWre = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: got Busy=%b Done=%b HI=%h LO=%h want 0 0 0 0", Busy, Done, HI, LO);
        end
        Reset = 1'b1;
        exp_hi = '0; exp_lo = '0;
    endtask

    task automatic test_directed();
        do_op("multu_max",  2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        checks++;
        if (HI !== 32'hFFFF_FFFE || LO !== 32'h0000_0001) begin
            errors++;
            $display("FAIL multu_max_const: got HI=%h LO=%h want fffffffe 00000001", HI, LO);
        end
        do_op("mult_neg",   2'b01, 32'hFFFF_FFFD, 32'd7, 0, 0);
        do_op("div_neg",    2'b11, 32'hFFFF_FFF9, 32'd2, 0, 0);
        do_op("divu_100_7", 2'b10, 32'd100, 32'd7, 0, 0);
        do_op("divu_zero",  2'b10, 32'h1234_5678, 32'd0, 0, 0);
        do_op("div_zero",   2'b11, 32'h8765_4321, 32'd0, 0, 0);
        do_op("div_ovf",    2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        do_op("mult_minmin",2'b01, 32'h8000_0000, 32'h8000_0000, 0, 0);
    endtask

    task automatic test_busy_ignore();
        do_op("busy_ignore", 2'b00, 32'd5, 32'd6, 0, 1);
    endtask

    task automatic test_mt_writes();
        mt_write(1, 0, 32'hAAAA_0000);
        mt_write(0, 1, 32'h0000_5555);
        mt_write(1, 1, 32'h1357_9BDF);
        mt_write(1, 0, 32'hAAAA_0000);
        do_op("start_with_hiwre", 2'b00, 32'h0000_0003, 32'h0000_0004, 1, 0);
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom);
            a  = $urandom;
            b  = $urandom;
            if (i % 4 == 1) b = 32'($urandom_range(1, 300));
            if (op[1] && $urandom_range(0, 7) == 0) b = 32'h0;
            do_op("random", op, a, b, 0, 0);
        end
    endtask

    task automatic test_async_reset();
        @(negedge CLK);
        Start = 1'b1; Op = 2'b00; SrcA = 32'h0001_0001; SrcB = 32'h0000_FFFF;
        @(negedge CLK);
        Start = 1'b0;
        repeat (15) @(negedge CLK);
        #2 Reset = 1'b0;
        #1;
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got Busy=%b Done=%b HI=%h LO=%h want 0 0 0 0", Busy, Done, HI, LO);
        end
        @(negedge CLK);
        Reset = 1'b1;
        exp_hi = '0; exp_lo = '0;
        do_op("after_reset", 2'b00, 32'd2, 32'd3, 0, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_mt_writes();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
